// File: rtl/dz_cfg_ctrl_if.sv
// rtl/dz_cfg_ctrl_if.sv - register-side and generator-side signal bundle for dz_cfg_ctrl
interface dz_cfg_ctrl_if #(
   parameter int DTG_W = 10
);
   logic             cfg_wr;
   logic             cfg_dze;
   logic             cfg_ccp;
   logic             cfg_ccnp;
   logic [DTG_W-1:0] cfg_dtg;
   logic             cfg_arpe;
   logic             upd_evt;
   logic             ocrefc;
   logic             dz_busy;
   logic             cfg_flag_clr;
   logic             r_dze;
   logic             r_ccp;
   logic             r_ccnp;
   logic [DTG_W-1:0] r_dtg;
   logic             cfg_pending;
   logic             cfg_commit;
   logic             cfg_ovr;
   logic             cfg_tmo;

   modport master (
      output cfg_wr, cfg_dze, cfg_ccp, cfg_ccnp, cfg_dtg, cfg_arpe,
      output upd_evt, ocrefc, dz_busy, cfg_flag_clr,
      input  r_dze, r_ccp, r_ccnp, r_dtg,
      input  cfg_pending, cfg_commit, cfg_ovr, cfg_tmo
   );

   modport slave (
      input  cfg_wr, cfg_dze, cfg_ccp, cfg_ccnp, cfg_dtg, cfg_arpe,
      input  upd_evt, ocrefc, dz_busy, cfg_flag_clr,
      output r_dze, r_ccp, r_ccnp, r_dtg,
      output cfg_pending, cfg_commit, cfg_ovr, cfg_tmo
   );
endinterface

// File: rtl/dz_cfg_ctrl.sv
// rtl/dz_cfg_ctrl.sv - dead-zone config sequencer: preload, update-gated safe commit
// Optional commit timeout enabled by defining DZ_CFG_TMO_EN.
module dz_cfg_ctrl #(
   parameter int DTG_W    = 10,
   parameter int SAFE_TMO = 255
) (
   input  logic          i_pe_gen_clk,
   input  logic          i_pe_gen_rst,
   dz_cfg_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PEND = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;

   logic             r_p_dze;
   logic             r_p_ccp;
   logic             r_p_ccnp;
   logic [DTG_W-1:0] r_p_dtg;
   logic             r_a_dze;
   logic             r_a_ccp;
   logic             r_a_ccnp;
   logic [DTG_W-1:0] r_a_dtg;

   logic             r_oc_d;
   logic             r_arm;
   logic             r_commit;
   logic             r_ovr;

   logic             w_ref_edge;
   logic             w_safe;
   logic             w_force;
   logic             w_commit;
   logic             w_ovr_set;
   logic             w_enter_wait;
   state_t           w_wr_dest;

   assign w_ref_edge = bus.ocrefc ^ r_oc_d;
   assign w_safe     = !bus.dz_busy && !w_ref_edge;
   assign w_wr_dest  = bus.cfg_arpe ? S_PEND : S_WAIT;

   always_comb begin
      w_next    = r_state;
      w_commit  = 1'b0;
      w_ovr_set = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.cfg_wr) begin
               w_next = w_wr_dest;
            end
         end
         S_PEND: begin
            w_ovr_set = bus.cfg_wr;
            if (bus.upd_evt) begin
               w_next = S_WAIT;
            end
         end
         S_WAIT: begin
            // First WAIT cycle only arms; commit is judged from the next cycle on
            if (r_arm && (w_safe || w_force)) begin
               w_commit = 1'b1;
               w_next   = bus.cfg_wr ? w_wr_dest : S_IDLE;
            end else begin
               w_ovr_set = bus.cfg_wr;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   assign w_enter_wait = (w_next == S_WAIT) && ((r_state != S_WAIT) || w_commit);

   always_ff @(posedge i_pe_gen_clk) begin
      if (i_pe_gen_rst) begin
         r_state  <= S_IDLE;
         r_oc_d   <= 1'b0;
         r_arm    <= 1'b0;
         r_commit <= 1'b0;
         r_ovr    <= 1'b0;
         r_p_dze  <= 1'b0;
         r_p_ccp  <= 1'b0;
         r_p_ccnp <= 1'b0;
         r_p_dtg  <= '0;
         r_a_dze  <= 1'b0;
         r_a_ccp  <= 1'b0;
         r_a_ccnp <= 1'b0;
         r_a_dtg  <= '0;
      end else begin
         r_state  <= w_next;
         r_oc_d   <= bus.ocrefc;
         r_arm    <= (w_next == S_WAIT) && !w_enter_wait;
         r_commit <= w_commit;
         r_ovr    <= w_ovr_set | (r_ovr & ~bus.cfg_flag_clr);
         if (bus.cfg_wr) begin
            r_p_dze  <= bus.cfg_dze;
            r_p_ccp  <= bus.cfg_ccp;
            r_p_ccnp <= bus.cfg_ccnp;
            r_p_dtg  <= bus.cfg_dtg;
         end
         // Active regs see the preload as it stood before any same-cycle write
         if (w_commit) begin
            r_a_dze  <= r_p_dze;
            r_a_ccp  <= r_p_ccp;
            r_a_ccnp <= r_p_ccnp;
            r_a_dtg  <= r_p_dtg;
         end
      end
   end

`ifdef DZ_CFG_TMO_EN
   localparam logic [7:0] TMO_LIM = 8'(SAFE_TMO);

   logic [7:0] r_tmo_cnt;
   logic       r_tmo;

   assign w_force = (r_tmo_cnt == TMO_LIM) && !w_safe;

   always_ff @(posedge i_pe_gen_clk) begin
      if (i_pe_gen_rst) begin
         r_tmo_cnt <= 8'd0;
         r_tmo     <= 1'b0;
      end else begin
         if (w_enter_wait) begin
            r_tmo_cnt <= 8'd0;
         end else if ((r_state == S_WAIT) && !w_safe) begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
         end
         r_tmo <= (w_commit & w_force) | (r_tmo & ~bus.cfg_flag_clr);
      end
   end

   assign bus.cfg_tmo = r_tmo;
`else
   logic w_unused_tmo;
   assign w_unused_tmo = ^8'(SAFE_TMO);
   assign w_force      = 1'b0;
   assign bus.cfg_tmo  = 1'b0;
`endif

   assign bus.r_dze       = r_a_dze;
   assign bus.r_ccp       = r_a_ccp;
   assign bus.r_ccnp      = r_a_ccnp;
   assign bus.r_dtg       = r_a_dtg;
   assign bus.cfg_pending = (r_state != S_IDLE);
   assign bus.cfg_commit  = r_commit;
   assign bus.cfg_ovr     = r_ovr;

endmodule

// File: doc/dz_cfg_ctrl.md
# dz_cfg_ctrl

Configuration sequencer for the channel dead-zone datapath of the advanced timer. It buffers software writes of dead-zone enable, output polarities and dead-time length in preload registers. It commits them to the active configuration driving the dead-zone generator only at a safe instant: after an update event when preload is enabled, with no dead-time interval running and no reference edge in the commit cycle. It sits in advtim_pe_core, between the register interface and the dead-zone generator.

## Interface
- DTG_W, 10, dead-time count width
- SAFE_TMO, 255, max unsafe cycles in WAIT before a forced commit (range 1..255)

- pe_gen_clk  in  1  clock
- pe_gen_rst  in  1  reset, synchronous, active-high
- cfg_wr  in  1  write strobe; captures cfg_* into preload
- cfg_dze / cfg_ccp / cfg_ccnp  in  1 each  new enable / P polarity / N polarity
- cfg_dtg  in  DTG_W  new dead-time count
- cfg_arpe  in  1  1 = commit on upd_evt; 0 = commit as soon as safe
- upd_evt  in  1  timer update event pulse
- ocrefc  in  1  channel reference waveform, also fed to the generator
- dz_busy  in  1  OR of the generator's channelp/channeln dead-zone outputs
- cfg_flag_clr  in  1  clears cfg_ovr and cfg_tmo
- r_dze / r_ccp / r_ccnp  out  1 each  active config to the generator
- r_dtg  out  DTG_W  active dead-time count
- cfg_pending  out  1  preload not yet committed
- cfg_commit  out  1  one-cycle pulse on the commit edge
- cfg_ovr  out  1  sticky; a write replaced an uncommitted preload
- cfg_tmo  out  1  sticky; a commit was forced by timeout

## Operation
- Preload regs p_dze, p_ccp, p_ccnp, p_dtg are loaded on every cfg_wr, in any state.
- States:
  - IDLE: on cfg_wr, go to PEND if cfg_arpe=1, else WAIT. upd_evt is ignored.
  - PEND: on upd_evt, go to WAIT.
  - WAIT: on safe, commit and go to IDLE.
- A cfg_wr in PEND or WAIT updates the preload, sets cfg_ovr and does not change state.
- cfg_wr and upd_evt in the same cycle:
  - In IDLE, the block goes to PEND. That upd_evt is not counted; the next one is needed.
  - In PEND, the block goes to WAIT with the new value.
- Edge detect: ocrefc_d is registered; edge = ocrefc ^ ocrefc_d.
- safe = !dz_busy && !edge.
- Commit action:
  - Active regs take the preload values.
  - cfg_commit = 1 for one cycle.
- cfg_wr in the commit cycle:
  - The old preload is committed.
  - The new value is captured into preload.
  - The next state is PEND or WAIT per cfg_arpe, not IDLE. cfg_ovr is not set.
- cfg_pending = (state != IDLE), decoded from the state register.
- Flags: a set has priority over cfg_flag_clr in the same cycle.
- Reset (pe_gen_rst=1 at a clock edge) applies from any state, including mid-WAIT. Reset values:
  - state = IDLE.
  - All preload and active regs = 0.
  - ocrefc_d = 0, timeout counter = 0.
  - cfg_pending, cfg_commit, cfg_ovr, cfg_tmo = 0.
  - The pending write is discarded.

## Timing
- All outputs are registered, or decoded from the state register only.
- Immediate mode: cfg_wr at edge n puts the block in WAIT from n+1. If safe at n+1, r_* and cfg_commit change at edge n+2. Minimum latency is 2 cycles.
- Preload mode: upd_evt sampled at edge m puts the block in WAIT. Commit happens at the earliest m+2.
- An edge on ocrefc in cycle k blocks commit in cycle k only. dz_busy rising in cycle k+1 then blocks the following cycles.
- r_* are stable except on the commit edge. The generator sees the new config from the cycle after cfg_commit rises.

## Configuration
- Macro: DZ_CFG_TMO_EN.
- Defined:
  - An 8-bit counter clears on entry to WAIT and increments on each unsafe cycle in WAIT.
  - When counter == SAFE_TMO and the cycle is still unsafe, commit is forced on that edge and cfg_tmo is set.
- Undefined:
  - No counter exists. WAIT waits for safe indefinitely.
  - cfg_tmo is tied to 0.

## Test plan
- Immediate commit: arpe=0, dz_busy=0, ocrefc constant, cfg_wr with dtg=10'd37, dze=1 -> cfg_commit pulses 2 cycles later; r_dtg=37, r_dze=1; cfg_pending high for exactly 2 cycles.
- Preload hold: arpe=1, cfg_wr dtg=5, no upd_evt for 50 cycles -> r_dtg stays 0, cfg_pending=1; upd_evt -> commit 2 cycles later.
- Safe gating: in WAIT, hold dz_busy=1 for 20 cycles, toggle ocrefc when it drops -> no commit until the first cycle with dz_busy=0 and no edge; exactly one cfg_commit pulse.
- Overwrite and simultaneous events: arpe=1, cfg_wr dtg=3, then cfg_wr dtg=9 together with upd_evt -> cfg_ovr=1, committed r_dtg=9; cfg_flag_clr -> cfg_ovr=0.
- Timeout (DZ_CFG_TMO_EN, SAFE_TMO=4): in WAIT, dz_busy held 1 -> forced commit on the 5th unsafe cycle, cfg_tmo=1. Without the macro: no commit, cfg_tmo=0.
- Reset mid-WAIT: pe_gen_rst=1 for one cycle while pending -> all outputs 0, state IDLE, no cfg_commit afterwards.
